// File: rtl/vga_row_fetch_ctrl.sv
// Row fetch / byte-step sequencer for the VGA byte-select datapath.
// Pulls one 1024-bit row from video RAM, then walks byte_idx across it under valid/ready.
module vga_row_fetch_ctrl #(
  parameter int ROW_BYTES = 128,
  parameter int NUM_ROWS  = 60,
  parameter int ROW_AW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic              ram_req,
  output logic [ROW_AW-1:0] ram_row,
  input  logic              ram_ack,
  input  logic [1023:0]     ram_data,
  output logic [1023:0]     row_bus,
  output logic [7:0]        byte_idx,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              row_done,
  output logic              frame_done,
  output logic              busy
);

  localparam int                LANES    = 128;
  localparam logic [7:0]        LAST_IDX = 8'(ROW_BYTES - 1);
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ROW_AW-1:0] row_reg, row_next;
  logic [7:0]        idx_reg, idx_next;
  logic              pend_reg, pend_next;
  logic              gap_reg, gap_next;
  logic              row_done_reg, row_done_next;
  logic              frame_done_reg, frame_done_next;
  logic              load_row;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg        <= '0;
      idx_reg        <= '0;
      pend_reg       <= 1'b0;
      gap_reg        <= 1'b0;
      row_done_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      row_reg        <= row_next;
      idx_reg        <= idx_next;
      pend_reg       <= pend_next;
      gap_reg        <= gap_next;
      row_done_reg   <= row_done_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next      = state_reg;
    row_next        = row_reg;
    idx_next        = idx_reg;
    pend_next       = pend_reg;
    gap_next        = 1'b0;
    row_done_next   = 1'b0;
    frame_done_next = 1'b0;
    load_row        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          state_next = FETCH;
          row_next   = '0;
          pend_next  = 1'b0;
        end
      end
      FETCH: begin
        // gap_reg marks the single idle cycle between a discarded read and the re-request
        if (!gap_reg) begin
          if (ram_ack) begin
            if (pend_reg || frame_start) begin
              pend_next = 1'b0;
              row_next  = '0;
              gap_next  = 1'b1;
            end else begin
              load_row   = 1'b1;
              idx_next   = '0;
              state_next = STREAM;
            end
          end else if (frame_start) begin
            pend_next = 1'b1;
          end
        end
      end
      STREAM: begin
        if (frame_start) begin
          state_next = FETCH;
          row_next   = '0;
          gap_next   = 1'b1;
        end else if (byte_ready) begin
          if (idx_reg == LAST_IDX) begin
            row_done_next = 1'b1;
            if (row_reg == LAST_ROW) begin
              frame_done_next = 1'b1;
              state_next      = IDLE;
            end else begin
              row_next   = row_reg + ROW_AW'(1);
              state_next = FETCH;
            end
          end else begin
            idx_next = idx_reg + 8'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    ram_req    = 1'b0;
    ram_row    = '0;
    byte_valid = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      FETCH: begin
        ram_req = !gap_reg;
        ram_row = row_reg;
      end
      STREAM: begin
        byte_valid = 1'b1;
      end
      default: begin
        ram_req = 1'b0;
      end
    endcase
  end

  assign byte_idx   = idx_reg;
  assign row_done   = row_done_reg;
  assign frame_done = frame_done_reg;

  // One byte lane per generate block; only an accepted, non-discarded ack reloads the row.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] lane_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_reg <= '0;
      end else if (load_row) begin
        lane_reg <= ram_data[8*gi +: 8];
      end
    end
    assign row_bus[8*gi +: 8] = lane_reg;
  end

endmodule

// File: tb/tb_vga_row_fetch_ctrl.sv
// Scoreboard bench for vga_row_fetch_ctrl: stimulus queues expected requests, beats and
// row/frame completions; a negedge monitor pops and compares as the DUT presents them.
module tb_vga_row_fetch_ctrl;

  localparam int RB = 128;
  localparam int NR = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          ram_req;
  logic [AW-1:0] ram_row;
  logic          ram_ack = 1'b0;
  logic [1023:0] ram_data = '0;
  logic [1023:0] row_bus;
  logic [7:0]    byte_idx;
  logic          byte_valid;
  logic          byte_ready = 1'b0;
  logic          row_done;
  logic          frame_done;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int ack_delay = 2;
  int wait_cnt = 0;
  int ready_mode = 0;
  int rc = 0;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] val;
  } beat_t;

  beat_t         beat_q[$];
  logic [AW-1:0] req_q[$];
  logic          done_q[$];

  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [7:0]    prev_idx = '0;
  logic [1023:0] prev_bus = '0;

  vga_row_fetch_ctrl #(
    .ROW_BYTES(RB),
    .NUM_ROWS (NR),
    .ROW_AW   (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .ram_req    (ram_req),
    .ram_row    (ram_row),
    .ram_ack    (ram_ack),
    .ram_data   (ram_data),
    .row_bus    (row_bus),
    .byte_idx   (byte_idx),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .row_done   (row_done),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference RAM contents: byte n of row r is n ^ (r*0x35), so row 0 holds byte n == n.
  function automatic logic [7:0] dbyte(int r, int n);
    logic [7:0] a;
    logic [7:0] b;
    a = 8'(n);
    b = 8'(r * 53);
    return a ^ b;
  endfunction

  function automatic logic [1023:0] row_word(int r);
    logic [1023:0] w;
    w = '0;
    for (int n = 0; n < RB; n++) w[8*n +: 8] = dbyte(r, n);
    return w;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_row(int r, int first, int last);
    for (int n = first; n <= last; n++) begin
      beat_t b;
      b.idx = 8'(n);
      b.val = dbyte(r, n);
      beat_q.push_back(b);
    end
  endtask

  task automatic push_frame();
    for (int r = 0; r < NR; r++) begin
      req_q.push_back(AW'(r));
      push_row(r, 0, RB - 1);
      done_q.push_back(r == NR - 1);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after the pulse.
  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame_done(string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic check_drained(string name);
    chk(name, 64'(beat_q.size() + req_q.size() + done_q.size()), 64'd0);
  endtask

  // RAM model: acks ack_delay cycles into a request
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ram_ack) begin
        ram_ack  = 1'b0;
        wait_cnt = 0;
      end
      if (ram_req) begin
        if (wait_cnt >= ack_delay) begin
          ram_ack  = 1'b1;
          ram_data = row_word(int'(ram_row));
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Downstream ready: constant 1, or the 1,0,0,1 backpressure pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rc++;
      if (ready_mode == 0) byte_ready = 1'b1;
      else byte_ready = ((rc % 4) == 0) || ((rc % 4) == 3);
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_req && ram_ack) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_row: got request for row %0d, expected none", ram_row);
        end else begin
          chk("ack_row", 64'(ram_row), 64'(req_q.pop_front()));
        end
      end
      if (byte_valid && byte_ready) begin
        if (beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat: got beat idx %0d, expected none", byte_idx);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_idx", 64'(byte_idx), 64'(b.idx));
          chk("beat_byte", 64'(row_bus[8*byte_idx +: 8]), 64'(b.val));
        end
      end
      if (row_done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL row_done: got pulse (frame_done=%0b), expected none", frame_done);
        end else begin
          chk("frame_done_at_row_done", 64'(frame_done), 64'(done_q.pop_front()));
        end
      end else if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL frame_done_alone: got frame_done without row_done, expected none");
      end
      if (prev_valid && !prev_ready && byte_valid) begin
        chk("stall_idx", 64'(byte_idx), 64'(prev_idx));
        chk("stall_bus", 64'(row_bus == prev_bus), 64'd1);
      end
      prev_valid = byte_valid;
      prev_ready = byte_ready;
      prev_idx   = byte_idx;
      prev_bus   = row_bus;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    bit seen;
    int rd_cnt;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ram_req", 64'(ram_req), 64'd0);
    chk("rst_byte_valid", 64'(byte_valid), 64'd0);
    chk("rst_row_done", 64'(row_done), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ram_row", 64'(ram_row), 64'd0);
    chk("rst_byte_idx", 64'(byte_idx), 64'd0);
    chk("rst_row_bus", 64'(row_bus == '0), 64'd1);
    rst_non: begin
      rst_n = 1'b1;
    end
    repeat (2) @(negedge clk);

    // Full frame, ready always high, ack two cycles after request
    ready_mode = 0;
    ack_delay  = 2;
    push_frame();
    pulse_start();
    chk("start_latency_req", 64'(ram_req), 64'd1);
    chk("start_latency_row", 64'(ram_row), 64'd0);
    wait_frame_done("frame1_done");
    @(negedge clk);
    chk("frame1_busy_after", 64'(busy), 64'd0);
    check_drained("frame1_drained");

    // Backpressure 1,0,0,1
    ready_mode = 1;
    push_frame();
    pulse_start();
    wait_frame_done("bp_frame_done");
    @(negedge clk);
    chk("bp_busy_after", 64'(busy), 64'd0);
    check_drained("bp_drained");
    ready_mode = 0;

    // Zero-wait ack
    ack_delay = 0;
    push_frame();
    pulse_start();
    chk("zw_ack_first_cycle", 64'(ram_req && ram_ack), 64'd1);
    @(negedge clk);
    chk("zw_valid", 64'(byte_valid), 64'd1);
    chk("zw_idx", 64'(byte_idx), 64'd0);
    chk("zw_top_byte", 64'(row_bus[1023:1016]), 64'h7F);
    wait_frame_done("zw_frame_done");
    @(negedge clk);
    check_drained("zw_drained");

    // Restart from STREAM at byte 50 of row 3
    ack_delay = 2;
    for (int r = 0; r < NR - 1; r++) begin
      req_q.push_back(AW'(r));
      push_row(r, 0, RB - 1);
      done_q.push_back(1'b0);
    end
    req_q.push_back(AW'(3));
    push_row(3, 0, 50);
    pulse_start();
    seen   = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (row_done) rd_cnt++;
      if (rd_cnt == 3 && byte_valid && byte_idx == 8'd50) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rs_reached_row3_idx50", 64'(seen), 64'd1);
    pulse_start();
    chk("rs_valid_drop", 64'(byte_valid), 64'd0);
    chk("rs_gap_req", 64'(ram_req), 64'd0);
    chk("rs_no_row_done", 64'(row_done), 64'd0);
    chk("rs_no_frame_done", 64'(frame_done), 64'd0);
    push_frame();
    @(negedge clk);
    chk("rs_refetch_req", 64'(ram_req), 64'd1);
    chk("rs_refetch_row", 64'(ram_row), 64'd0);
    wait_frame_done("rs_frame_done");
    @(negedge clk);
    check_drained("rs_drained");

    // Restart during FETCH of row 1, ack five cycles late
    ack_delay = 5;
    req_q.push_back(AW'(0));
    push_row(0, 0, RB - 1);
    done_q.push_back(1'b0);
    req_q.push_back(AW'(1));
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (row_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("fr_row0_done", 64'(seen), 64'd1);
    chk("fr_req_row1", 64'(ram_req && ram_row == AW'(1)), 64'd1);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("fr_hold_req", 64'(ram_req), 64'd1);
      chk("fr_hold_row", 64'(ram_row), 64'd1);
      if (ram_ack) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("fr_old_ack_seen", 64'(seen), 64'd1);
    @(negedge clk);
    chk("fr_gap_req", 64'(ram_req), 64'd0);
    chk("fr_gap_valid", 64'(byte_valid), 64'd0);
    push_frame();
    @(negedge clk);
    chk("fr_refetch_req", 64'(ram_req), 64'd1);
    chk("fr_refetch_row", 64'(ram_row), 64'd0);
    wait_frame_done("fr_frame_done");
    @(negedge clk);
    check_drained("fr_drained");

    // Asynchronous reset mid-STREAM
    ack_delay = 2;
    req_q.push_back(AW'(0));
    push_row(0, 0, 20);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (byte_valid && byte_idx == 8'd20) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ar_reached_idx20", 64'(seen), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_byte_valid", 64'(byte_valid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_ram_req", 64'(ram_req), 64'd0);
    chk("ar_byte_idx", 64'(byte_idx), 64'd0);
    chk("ar_ram_row", 64'(ram_row), 64'd0);
    chk("ar_row_bus", 64'(row_bus == '0), 64'd1);
    check_drained("ar_drained");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || ram_req || byte_valid) seen = 1'b1;
    end
    chk("ar_stays_idle", 64'(seen), 64'd0);
    pulse_start();
    chk("ar_restart_req", 64'(ram_req), 64'd1);
    chk("ar_restart_row", 64'(ram_row), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_drop_req", 64'(ram_req), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
